// File: rtl/serv_uart_tx_if.sv
// Byte handshake between a serv core (producer) and the UART transmitter.
// Transfer happens on a cycle where valid_i && ready_o.
interface serv_uart_tx_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/serv_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO; drives one io pad (tx_o/oeb_o).
// state | meaning: IDLE line high, wait for data | START start bit | DATA 8 bits LSB first | STOP stop bit
module serv_uart_tx #(
  parameter int CLK_DIV    = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  serv_uart_tx_if.slave               bus,
  output logic                        tx_o,
  output logic                        oeb_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              LW         = AW + 1;
  localparam logic [LW-1:0]   FULL_LVL   = LW'(FIFO_DEPTH);
  localparam logic [15:0]     DIV_RELOAD = 16'(CLK_DIV - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q, oeb_q, busy_q;
  logic          tx_q, tx_d;
  logic [1:0]    state_q, state_d;
  logic [15:0]   div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, pop, bit_tick, fifo_nonempty;

  assign push          = bus.valid_i && ready_q;
  assign bit_tick      = (div_q == 16'd0);
  assign fifo_nonempty = (level_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == ST_IDLE) ? div_q : div_q - 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = ST_START;
          div_d   = DIV_RELOAD;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d = ST_DATA;
          div_d   = DIV_RELOAD;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          div_d = DIV_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          div_d = DIV_RELOAD;
          // Pending byte chains straight into the next start bit, no idle gap.
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      oeb_q    <= 1'b1;
      busy_q   <= 1'b0;
      tx_q     <= 1'b1;
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      // Reflects occupancy only, so a pop on a full FIFO reopens ready_o one cycle later.
      ready_q  <= (level_d != FULL_LVL);
      oeb_q    <= 1'b0;
      busy_q   <= (state_q != ST_IDLE) || fifo_nonempty;
      tx_q     <= tx_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= bus.data_i;
  end

  assign bus.ready_o = ready_q;
  assign tx_o        = tx_q;
  assign oeb_o       = oeb_q;
  assign busy_o      = busy_q;
  assign level_o     = level_q;

endmodule

// File: tb/tb_serv_uart_tx.sv
// Directed bench for serv_uart_tx: three instances (CLK_DIV 4, 8, 2) share clock and reset.
module tb_serv_uart_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serv_uart_tx_if if4 ();
  serv_uart_tx_if if8 ();
  serv_uart_tx_if if2 ();

  logic       tx4, oeb4, busy4, tx8, oeb8, busy8, tx2, oeb2, busy2;
  logic [2:0] lvl4, lvl8, lvl2;

  serv_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(4)) u_div4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if4),
    .tx_o(tx4), .oeb_o(oeb4), .busy_o(busy4), .level_o(lvl4));

  serv_uart_tx #(.CLK_DIV(8), .FIFO_DEPTH(4)) u_div8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if8),
    .tx_o(tx8), .oeb_o(oeb8), .busy_o(busy8), .level_o(lvl8));

  serv_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) u_div2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(if2),
    .tx_o(tx2), .oeb_o(oeb2), .busy_o(busy2), .level_o(lvl2));

  int   n_chk = 0;
  int   n_err = 0;
  int   sel   = 0;
  logic tx_mux;

  always_comb begin
    tx_mux = tx2;
    if (sel == 0) tx_mux = tx4;
    else if (sel == 1) tx_mux = tx8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[k-1];
  endfunction

  // Entry: at the negedge where the start bit first shows; exit: 10*div cycles later.
  task automatic check_frame(input logic [7:0] b, input int div, input string tag);
    for (int c = 0; c < 10*div; c++) begin
      chk($sformatf("%s_c%0d", tag, c), {31'd0, tx_mux}, {31'd0, fbit(b, c/div)});
      @(negedge clk);
    end
  endtask

  // Mid-bit sampling receiver; skip = frame cycles already elapsed at entry.
  task automatic rx_frame(input int div, input int skip, input logic [7:0] exp, input string tag);
    int cur;
    logic [7:0] b;
    cur = skip;
    b   = '0;
    for (int i = 0; i < 10; i++) begin
      while (cur < div/2 + i*div) begin
        @(negedge clk);
        cur++;
      end
      if (i == 0)      chk({tag, "_start"}, {31'd0, tx_mux}, 32'd0);
      else if (i == 9) chk({tag, "_stop"},  {31'd0, tx_mux}, 32'd1);
      else             b[i-1] = tx_mux;
    end
    chk({tag, "_byte"}, {24'd0, b}, {24'd0, exp});
  endtask

  task automatic wait_fall(input int max, input string tag);
    int n;
    n = 0;
    while (tx_mux !== 1'b0 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, tx_mux}, 32'd0);
  endtask

  initial begin
    int zeros;
    if4.data_i = '0; if4.valid_i = 1'b0;
    if8.data_i = '0; if8.valid_i = 1'b0;
    if2.data_i = '0; if2.valid_i = 1'b0;

    // Reset / idle
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_tx4",    {31'd0, tx4},         32'd1);
    chk("rst_oeb4",   {31'd0, oeb4},        32'd1);
    chk("rst_ready4", {31'd0, if4.ready_o}, 32'd0);
    chk("rst_busy4",  {31'd0, busy4},       32'd0);
    chk("rst_lvl4",   {29'd0, lvl4},        32'd0);
    chk("rst_tx8",    {31'd0, tx8},         32'd1);
    chk("rst_oeb2",   {31'd0, oeb2},        32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_oeb4",   {31'd0, oeb4},        32'd0);
    chk("rel_ready4", {31'd0, if4.ready_o}, 32'd1);
    chk("rel_busy4",  {31'd0, busy4},       32'd0);
    chk("rel_lvl4",   {29'd0, lvl4},        32'd0);
    chk("rel_oeb8",   {31'd0, oeb8},        32'd0);
    chk("rel_ready2", {31'd0, if2.ready_o}, 32'd1);

    // Single byte 0xA5, CLK_DIV=4
    sel = 0;
    if4.data_i = 8'hA5; if4.valid_i = 1'b1;
    @(negedge clk);
    if4.valid_i = 1'b0;
    chk("single_pre_tx", {31'd0, tx4},  32'd1);
    chk("single_lvl1",   {29'd0, lvl4}, 32'd1);
    @(negedge clk);
    chk("single_busy",   {31'd0, busy4}, 32'd1);
    chk("single_lvl0",   {29'd0, lvl4},  32'd0);
    check_frame(8'hA5, 4, "single");
    chk("single_idle_tx", {31'd0, tx4}, 32'd1);
    @(negedge clk);
    chk("single_busy_drop", {31'd0, busy4}, 32'd0);

    // Back-to-back 0x00 then 0xFF
    if4.data_i = 8'h00; if4.valid_i = 1'b1;
    @(negedge clk);
    if4.data_i = 8'hFF;
    chk("b2b_pre_tx", {31'd0, tx4}, 32'd1);
    @(negedge clk);
    if4.valid_i = 1'b0;
    check_frame(8'h00, 4, "b2b0");
    check_frame(8'hFF, 4, "b2b1");
    chk("b2b_idle_tx", {31'd0, tx4}, 32'd1);
    repeat (2) @(negedge clk);
    chk("b2b_busy_drop", {31'd0, busy4}, 32'd0);

    // Full FIFO, CLK_DIV=8: six bytes with valid held
    sel = 1;
    if8.data_i = 8'h11; if8.valid_i = 1'b1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      if8.data_i = 8'(8'h11 + i);
    end
    @(negedge clk);
    if8.data_i = 8'h16;
    chk("full_ready0", {31'd0, if8.ready_o}, 32'd0);
    chk("full_lvl4",   {29'd0, lvl8},        32'd4);
    chk("full_busy",   {31'd0, busy8},       32'd1);
    rx_frame(8, 3, 8'h11, "full_f1");
    chk("full_hold_ready0", {31'd0, if8.ready_o}, 32'd0);
    chk("full_hold_lvl4",   {29'd0, lvl8},        32'd4);
    wait_fall(20, "full_f2_fall");
    chk("full_pop_ready1", {31'd0, if8.ready_o}, 32'd1);
    chk("full_pop_lvl3",   {29'd0, lvl8},        32'd3);
    @(negedge clk);
    if8.valid_i = 1'b0;
    chk("full_6th_lvl4", {29'd0, lvl8}, 32'd4);
    rx_frame(8, 1, 8'h12, "full_f2");
    for (int k = 2; k < 6; k++) begin
      wait_fall(20, $sformatf("full_f%0d_fall", k+1));
      rx_frame(8, 0, 8'(8'h11 + k), $sformatf("full_f%0d", k+1));
    end
    repeat (8) @(negedge clk);
    chk("full_end_busy", {31'd0, busy8}, 32'd0);
    chk("full_end_lvl",  {29'd0, lvl8},  32'd0);
    chk("full_end_tx",   {31'd0, tx8},   32'd1);

    // Reset mid-frame during DATA bit 3
    sel = 0;
    if4.data_i = 8'h3C; if4.valid_i = 1'b1;
    @(negedge clk);
    if4.data_i = 8'h3D;
    @(negedge clk);
    if4.valid_i = 1'b0;
    chk("midrst_start", {31'd0, tx4}, 32'd0);
    repeat (17) @(negedge clk);
    chk("midrst_bit3", {31'd0, tx4},  32'd1);
    chk("midrst_lvl1", {29'd0, lvl4}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_tx",   {31'd0, tx4},   32'd1);
    chk("midrst_lvl",  {29'd0, lvl4},  32'd0);
    chk("midrst_busy", {31'd0, busy4}, 32'd0);
    chk("midrst_oeb",  {31'd0, oeb4},  32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    zeros = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx4 !== 1'b1) zeros++;
    end
    chk("midrst_no_resume", zeros,              32'd0);
    chk("midrst_after_lvl", {29'd0, lvl4},      32'd0);
    chk("midrst_after_rdy", {31'd0, if4.ready_o}, 32'd1);

    // Divider extreme, CLK_DIV=2
    sel = 2;
    if2.data_i = 8'h55; if2.valid_i = 1'b1;
    @(negedge clk);
    if2.valid_i = 1'b0;
    chk("div2_pre_tx", {31'd0, tx2}, 32'd1);
    @(negedge clk);
    check_frame(8'h55, 2, "div2");
    chk("div2_end_tx", {31'd0, tx2}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/serv_uart_tx.md
Name: serv_uart_tx

Overview:
- Byte-stream UART transmitter that consumes characters produced by a serv core and drives one io pad of that core's slice in the user project wrapper.
- Sits directly downstream of a serv instance and upstream of the pad: serv core -> serv_uart_tx -> io_out/io_oeb.
- Contains a small FIFO, a baud-rate divider and an 8N1 framing state machine.

Parameters:
- CLK_DIV, 104, wb_clk_i cycles per UART bit; legal range 2..65535.
- FIFO_DEPTH, 4, byte entries; power of two, 2..16.

Ports:
- wb_clk_i  input  1  system clock; all logic on the rising edge.
- wb_rst_i  input  1  asynchronous, active-high reset.
- data_i  input  8  byte to transmit, LSB sent first.
- valid_i  input  1  data_i is valid this cycle.
- ready_o  output  1  FIFO can accept a byte; transfer occurs when valid_i && ready_o.
- tx_o  output  1  serial line to io_out; idle high.
- oeb_o  output  1  pad output-enable-bar to io_oeb; 0 = pad driven.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values (asynchronous, while wb_rst_i=1):
  - tx_o=1, oeb_o=1, busy_o=0, level_o=0, ready_o=0.
  - FIFO pointers cleared; state=IDLE; divider and bit counter cleared.
- First cycle after reset deassertion:
  - oeb_o=0.
  - ready_o=1.
- FIFO:
  - Write on valid_i && ready_o.
  - ready_o = (level_o != FIFO_DEPTH), registered from occupancy; no combinational path from valid_i.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop with the FIFO full: the pop frees a slot, but ready_o stays low in that cycle because it reflects the previous level. No byte is lost or duplicated.
  - Push and pop in the same cycle: level_o is unchanged.
  - valid_i while ready_o=0: ignored; the producer must hold.
- Divider:
  - 16-bit counter.
  - Reloads to CLK_DIV-1 on every state entry.
  - Decrements each cycle; bit_tick is asserted when it reaches 0.
- State machine:
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head into the shift register and go to START. The pop occurs on the transition cycle.
  - START: tx_o=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for CLK_DIV cycles per bit. Shift right on bit_tick. After bit index 7, go to STOP.
  - STOP: tx_o=1 for CLK_DIV cycles, then go to IDLE.
  - Back-to-back: if the FIFO is non-empty at the end of STOP, go directly to START and pop in the same cycle. No idle bit is inserted.
- Timing:
  - Frame length is exactly 10*CLK_DIV cycles.
  - Latency from an accepted byte (empty FIFO, IDLE) to the tx_o falling edge is 2 cycles: 1 cycle for the FIFO write, 1 cycle for the pop/transition.
  - tx_o is registered (glitch-free).
- busy_o = (state != IDLE) || (level_o != 0), registered.
- Reset mid-frame: tx_o returns to 1 immediately (asynchronously) and FIFO contents are discarded. After reset no partial frame resumes.
- No parity, no flow-control input, no break generation.

Test Plan:
- Reset/idle:
  - Stimulus: assert wb_rst_i for 5 cycles, then release.
  - Required: during reset, tx_o=1 and oeb_o=1. One cycle after release, oeb_o=0 and ready_o=1. busy_o=0 and level_o=0.
- Single byte (CLK_DIV=4):
  - Stimulus: push 0xA5.
  - Required: tx_o falls 2 cycles later. Line sequence is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total). busy_o drops the cycle after STOP ends.
- Back-to-back:
  - Stimulus: push 0x00 then 0xFF on consecutive cycles.
  - Required: 20 contiguous bit periods with no idle gap. The second start bit immediately follows the first stop bit.
- Full FIFO (FIFO_DEPTH=4, CLK_DIV=8):
  - Stimulus: push 6 bytes 0x11..0x16 with valid_i held.
  - Required:
    - 5 accepted immediately: 1 popped into the shift register, 4 queued.
    - ready_o=0 and level_o=4.
    - The 6th byte is accepted only after the next pop.
    - All 6 bytes are transmitted in order.
- Reset mid-frame:
  - Stimulus: push 0x3C and 0x3D; assert wb_rst_i during DATA bit 3.
  - Required: tx_o=1 in the same cycle. After release, no further start bit appears and level_o=0.
- Divider extreme:
  - Stimulus: CLK_DIV=2, push 0x55.
  - Required: tx_o toggles every 2 cycles across the data bits. Frame length is 20 cycles.
